// File: rtl/jt12_timers_ab_if.sv
// Register/status side of the YM2612/YM2203 timer A/B block.
// master: register file / divider side that programs the timers.
// slave : the timer block itself.
interface jt12_timers_ab_if;
  logic       clk_en;
  logic [9:0] value_a;
  logic [7:0] value_b;
  logic       load_a;
  logic       load_b;
  logic       flagen_a;
  logic       flagen_b;
  logic       clr_flag_a;
  logic       clr_flag_b;
  logic       csm_en;
  logic       flag_a;
  logic       flag_b;
  logic       overflow_a;
  logic       irq_n;
  logic       csm_keyon;

  modport master (
    output clk_en, value_a, value_b, load_a, load_b,
    output flagen_a, flagen_b, clr_flag_a, clr_flag_b, csm_en,
    input  flag_a, flag_b, overflow_a, irq_n, csm_keyon
  );

  modport slave (
    input  clk_en, value_a, value_b, load_a, load_b,
    input  flagen_a, flagen_b, clr_flag_a, clr_flag_b, csm_en,
    output flag_a, flag_b, overflow_a, irq_n, csm_keyon
  );
endinterface

// File: rtl/jt12_timers_ab.sv
// YM2612/YM2203 timer A (10-bit) and timer B (8-bit).
// Both counters count up from their preset and reload on overflow; the
// prescaler chain (A_PRES clk_en per A tick, B_PRES A ticks per B tick)
// free-runs from reset regardless of the load bits.
// Optional feature macro: JT12_TMR_CSM_EN builds the CSM key-on pulse;
// when undefined csm_keyon is tied low and csm_en is ignored.
module jt12_timers_ab #(
  parameter int A_PRES = 24,
  parameter int B_PRES = 16
) (
  input  logic              clk,
  input  logic              rst,
  jt12_timers_ab_if.slave   tmr
);

  localparam int PA_W = (A_PRES > 1) ? $clog2(A_PRES) : 1;
  localparam int PB_W = (B_PRES > 1) ? $clog2(B_PRES) : 1;
  localparam logic [PA_W-1:0] PA_LAST = PA_W'(A_PRES - 1);
  localparam logic [PB_W-1:0] PB_LAST = PB_W'(B_PRES - 1);

  logic [PA_W-1:0] pre_a_q, pre_a_d;
  logic [PB_W-1:0] pre_b_q, pre_b_d;
  logic [9:0]      cnt_a_q, cnt_a_d;
  logic [7:0]      cnt_b_q, cnt_b_d;
  logic            load_a_l_q, load_b_l_q;
  logic            flag_a_q, flag_a_d;
  logic            flag_b_q, flag_b_d;
  logic            ovf_a_q;
  logic            csm_q, csm_d;
  logic            tick_a, tick_b;
  logic            ledge_a, ledge_b;
  logic            ovf_a, ovf_b;

  // Prescaler chain: one A tick per A_PRES clk_en, one B tick per B_PRES A ticks.
  always_comb begin
    pre_a_d = pre_a_q;
    pre_b_d = pre_b_q;
    tick_a  = 1'b0;
    tick_b  = 1'b0;
    if (tmr.clk_en) begin
      if (pre_a_q == PA_LAST) begin
        pre_a_d = '0;
        tick_a  = 1'b1;
      end else begin
        pre_a_d = pre_a_q + PA_W'(1);
      end
    end
    if (tick_a) begin
      if (pre_b_q == PB_LAST) begin
        pre_b_d = '0;
        tick_b  = 1'b1;
      end else begin
        pre_b_d = pre_b_q + PB_W'(1);
      end
    end
  end

  // Counters: a load edge wins over a coincident tick; overflow reloads the preset.
  always_comb begin
    ledge_a = tmr.load_a & ~load_a_l_q;
    ledge_b = tmr.load_b & ~load_b_l_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    ovf_a   = 1'b0;
    ovf_b   = 1'b0;
    if (ledge_a) begin
      cnt_a_d = tmr.value_a;
    end else if (tmr.load_a && tick_a) begin
      if (&cnt_a_q) begin
        cnt_a_d = tmr.value_a;
        ovf_a   = 1'b1;
      end else begin
        cnt_a_d = cnt_a_q + 10'd1;
      end
    end
    if (ledge_b) begin
      cnt_b_d = tmr.value_b;
    end else if (tmr.load_b && tick_b) begin
      if (&cnt_b_q) begin
        cnt_b_d = tmr.value_b;
        ovf_b   = 1'b1;
      end else begin
        cnt_b_d = cnt_b_q + 8'd1;
      end
    end
  end

  // Status flags: a set in the same clock as a clear takes priority.
  always_comb begin
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    if (ovf_a && tmr.flagen_a) begin
      flag_a_d = 1'b1;
    end else if (tmr.clr_flag_a) begin
      flag_a_d = 1'b0;
    end
    if (ovf_b && tmr.flagen_b) begin
      flag_b_d = 1'b1;
    end else if (tmr.clr_flag_b) begin
      flag_b_d = 1'b0;
    end
  end

`ifdef JT12_TMR_CSM_EN
  // CSM key-on follows every timer A overflow while CSM mode is selected.
  always_comb begin
    csm_d = ovf_a & tmr.csm_en;
  end
`else
  logic unused_csm_en;
  assign unused_csm_en = tmr.csm_en;
  assign csm_d         = 1'b0;
`endif

  // State registers; reset clears everything, including the load edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_a_q    <= '0;
      pre_b_q    <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      load_a_l_q <= 1'b0;
      load_b_l_q <= 1'b0;
      flag_a_q   <= 1'b0;
      flag_b_q   <= 1'b0;
      ovf_a_q    <= 1'b0;
      csm_q      <= 1'b0;
    end else begin
      pre_a_q    <= pre_a_d;
      pre_b_q    <= pre_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      load_a_l_q <= tmr.load_a;
      load_b_l_q <= tmr.load_b;
      flag_a_q   <= flag_a_d;
      flag_b_q   <= flag_b_d;
      ovf_a_q    <= ovf_a;
      csm_q      <= csm_d;
    end
  end

  assign tmr.flag_a     = flag_a_q;
  assign tmr.flag_b     = flag_b_q;
  assign tmr.overflow_a = ovf_a_q;
  assign tmr.irq_n      = ~(flag_a_q | flag_b_q);
  assign tmr.csm_keyon  = csm_q;

endmodule

// File: tb/tb_jt12_timers_ab.sv
// Bench for jt12_timers_ab: directed scenarios plus a randomized soak, every
// clock compared against a reference model built from tick arithmetic and a
// "ticks remaining until overflow" count per timer.
module tb_jt12_timers_ab;
  localparam int AP = 24;
  localparam int BP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc_n = 0;

  jt12_timers_ab_if bus();

  jt12_timers_ab #(.A_PRES(AP), .B_PRES(BP)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_n;          // clk_en pulses seen since reset
  int m_rem_a;      // A ticks left until overflow
  int m_rem_b;      // B ticks left until overflow
  bit m_prev_a, m_prev_b, m_fa, m_fb, m_oa, m_key;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc_n);
  endtask

  function automatic void model_reset();
    m_n = 0; m_rem_a = 1024; m_rem_b = 256;
    m_prev_a = 0; m_prev_b = 0;
    m_fa = 0; m_fb = 0; m_oa = 0; m_key = 0;
  endfunction

  function automatic void model_step();
    bit ta, tb_, ea, eb, ob;
    ta  = bus.clk_en && (m_n % AP == AP - 1);
    tb_ = bus.clk_en && (m_n % (AP * BP) == AP * BP - 1);
    if (bus.clk_en) m_n++;
    ea = bus.load_a && !m_prev_a;
    eb = bus.load_b && !m_prev_b;
    m_prev_a = bus.load_a;
    m_prev_b = bus.load_b;
    m_oa = 0; ob = 0;
    if (ea) m_rem_a = 1024 - int'(bus.value_a);
    else if (bus.load_a && ta) begin
      m_rem_a--;
      if (m_rem_a == 0) begin m_oa = 1; m_rem_a = 1024 - int'(bus.value_a); end
    end
    if (eb) m_rem_b = 256 - int'(bus.value_b);
    else if (bus.load_b && tb_) begin
      m_rem_b--;
      if (m_rem_b == 0) begin ob = 1; m_rem_b = 256 - int'(bus.value_b); end
    end
    if (m_oa && bus.flagen_a) m_fa = 1; else if (bus.clr_flag_a) m_fa = 0;
    if (ob && bus.flagen_b) m_fb = 1; else if (bus.clr_flag_b) m_fb = 0;
`ifdef JT12_TMR_CSM_EN
    m_key = m_oa && bus.csm_en;
`else
    m_key = 0;
`endif
  endfunction

  // True when the coming clock edge will overflow timer A.
  function automatic bit next_ovf_a();
    return bus.clk_en && (m_n % AP == AP - 1) && bus.load_a && m_prev_a && (m_rem_a == 1);
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    cyc_n++;
    #1;
    chk("flag_a", int'(bus.flag_a), int'(m_fa));
    chk("flag_b", int'(bus.flag_b), int'(m_fb));
    chk("overflow_a", int'(bus.overflow_a), int'(m_oa));
    chk("irq_n", int'(bus.irq_n), int'(!(m_fa || m_fb)));
    chk("csm_keyon", int'(bus.csm_keyon), int'(m_key));
  endtask

  initial begin
    int last, got, edge_n, cnt;
    bit ok;
    bus.clk_en = 1; bus.value_a = '0; bus.value_b = '0;
    bus.load_a = 0; bus.load_b = 0; bus.flagen_a = 0; bus.flagen_b = 0;
    bus.clr_flag_a = 0; bus.clr_flag_b = 0; bus.csm_en = 0;
    model_reset();
    repeat (3) cyc();
    chk("rst_irq_n", int'(bus.irq_n), 1);
    rst = 0;
    repeat (5) cyc();

    // Timer A period 96 clk at value 1020, flag and irq follow
    bus.value_a = 10'd1020; bus.flagen_a = 1; bus.load_a = 1;
    last = -1; got = 0;
    for (int i = 0; i < 600 && got < 4; i++) begin
      cyc();
      if (bus.overflow_a) begin
        if (last >= 0) chk("t1_period", cyc_n - last, 96);
        last = cyc_n; got++;
      end
    end
    chk("t1_count", got, 4);
    chk("t1_flag_a", int'(bus.flag_a), 1);
    chk("t1_irq_n", int'(bus.irq_n), 0);

    // Timer B with flag disabled, then period 768 with flag enabled
    bus.load_a = 0; bus.clr_flag_a = 1; cyc(); bus.clr_flag_a = 0;
    bus.value_b = 8'd254; bus.flagen_b = 0; bus.load_b = 1;
    repeat (1600) cyc();
    chk("t2_flag_b_off", int'(bus.flag_b), 0);
    chk("t2_irq_n", int'(bus.irq_n), 1);
    bus.flagen_b = 1; last = -1; got = 0;
    for (int i = 0; i < 3000 && got < 3; i++) begin
      cyc();
      bus.clr_flag_b = 0;
      if (bus.flag_b) begin
        if (last >= 0) chk("t2_period", cyc_n - last, 768);
        last = cyc_n; got++; bus.clr_flag_b = 1;
      end
    end
    chk("t2_count", got, 3);
    cyc(); bus.clr_flag_b = 0; bus.flagen_b = 0; bus.load_b = 0;
    cyc();

    // Set beats clear in the same clock; clear alone works
    bus.value_a = 10'd1020; bus.flagen_a = 1; bus.load_a = 1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin cyc(); ok = bus.flag_a; end
    chk("t3_flag_set", int'(ok), 1);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin if (next_ovf_a()) ok = 1; else cyc(); end
    chk("t3_wait", int'(ok), 1);
    bus.clr_flag_a = 1; cyc(); bus.clr_flag_a = 0;
    chk("t3_ovf", int'(bus.overflow_a), 1);
    chk("t3_set_wins", int'(bus.flag_a), 1);
    cyc(); bus.clr_flag_a = 1; cyc(); bus.clr_flag_a = 0;
    chk("t3_clr", int'(bus.flag_a), 0);

    // Hold while load low, reload on edge coinciding with a tick
    bus.load_a = 0; cyc();
    bus.value_a = 10'd1000; bus.load_a = 1;
    repeat (100) cyc();
    bus.load_a = 0; cnt = 0;
    for (int i = 0; i < 200; i++) begin cyc(); if (bus.overflow_a) cnt++; end
    chk("t4_hold_no_ovf", cnt, 0);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (bus.clk_en && (m_n % AP == AP - 1)) ok = 1; else cyc();
    end
    chk("t4_align", int'(ok), 1);
    bus.load_a = 1; cyc(); edge_n = cyc_n; ok = 0;
    for (int i = 0; i < 800 && !ok; i++) begin cyc(); ok = bus.overflow_a; end
    chk("t4_seen", int'(ok), 1);
    chk("t4_delay", cyc_n - edge_n, 576);

    // CSM key-on at value 1023
    bus.load_a = 0; bus.flagen_a = 0; bus.clr_flag_a = 1; cyc(); bus.clr_flag_a = 0;
    bus.value_a = 10'd1023; bus.csm_en = 1; bus.load_a = 1;
    last = -1; cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (bus.csm_keyon) begin
        if (last >= 0) chk("t5_period", cyc_n - last, 24);
        last = cyc_n; cnt++;
      end
    end
`ifdef JT12_TMR_CSM_EN
    chk("t5_pulses", int'(cnt >= 7), 1);
`else
    chk("t5_pulses", cnt, 0);
`endif
    bus.csm_en = 0; bus.load_a = 0; cyc();

    // Asynchronous reset mid-count with both flags set
    bus.value_a = 10'd1020; bus.value_b = 8'd255;
    bus.flagen_a = 1; bus.flagen_b = 1; bus.load_a = 1; bus.load_b = 1;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin cyc(); ok = bus.flag_a && bus.flag_b; end
    chk("t6_flags_set", int'(ok), 1);
    cyc();
    #2 rst = 1;
    #1;
    model_reset();
    chk("t6_rst_flag_a", int'(bus.flag_a), 0);
    chk("t6_rst_flag_b", int'(bus.flag_b), 0);
    chk("t6_rst_irq_n", int'(bus.irq_n), 1);
    chk("t6_rst_ovf", int'(bus.overflow_a), 0);
    chk("t6_rst_csm", int'(bus.csm_keyon), 0);
    bus.load_a = 0; bus.load_b = 0;
    repeat (3) cyc();
    rst = 0; cnt = 0;
    for (int i = 0; i < 1500; i++) begin cyc(); if (bus.overflow_a) cnt++; end
    chk("t6_no_ovf", cnt, 0);
    bus.load_a = 1; cnt = 0;
    for (int i = 0; i < 150; i++) begin cyc(); if (bus.overflow_a) cnt++; end
    chk("t6_runs_again", int'(cnt >= 1), 1);

    // Randomized soak
    for (int ph = 0; ph < 10; ph++) begin
      bus.value_a = 10'(1024 - $urandom_range(1, 8));
      bus.value_b = 8'(256 - $urandom_range(1, 3));
      bus.flagen_a = 1'($urandom_range(0, 1));
      bus.flagen_b = 1'($urandom_range(0, 1));
      bus.csm_en = 1'($urandom_range(0, 1));
      bus.load_a = 1'($urandom_range(0, 1));
      bus.load_b = 1'($urandom_range(0, 1));
      for (int i = 0; i < 1500; i++) begin
        bus.clk_en = ($urandom_range(0, 9) != 0);
        bus.clr_flag_a = ($urandom_range(0, 49) == 0);
        bus.clr_flag_b = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 199) == 0) bus.load_a = ~bus.load_a;
        if ($urandom_range(0, 299) == 0) bus.load_b = ~bus.load_b;
        if ($urandom_range(0, 99) == 0) bus.value_a = 10'(1024 - $urandom_range(1, 8));
        if ($urandom_range(0, 99) == 0) bus.value_b = 8'(256 - $urandom_range(1, 3));
        cyc();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
